// File: rtl/mips_core.svh
// Shared bus geometry for the MIPS core and its memory-side peripherals.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`endif

// File: rtl/axi_mem_responder.sv
// AXI3-style word-addressed memory slave: independent read and write FSMs,
// incrementing bursts, one outstanding transaction per direction.
`include "mips_core.svh"

module axi_mem_responder #(
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   AWREADY,
  input  logic                   AWVALID,
  input  logic [3:0]             AWID,
  input  logic [3:0]             AWLEN,
  input  logic [`ADDR_WIDTH-1:0] AWADDR,
  output logic                   WREADY,
  input  logic                   WVALID,
  input  logic                   WLAST,
  input  logic [3:0]             WID,
  input  logic [`DATA_WIDTH-1:0] WDATA,
  input  logic                   BREADY,
  output logic                   BVALID,
  output logic [3:0]             BID,
  output logic                   ARREADY,
  input  logic                   ARVALID,
  input  logic [3:0]             ARID,
  input  logic [3:0]             ARLEN,
  input  logic [`ADDR_WIDTH-1:0] ARADDR,
  input  logic                   RREADY,
  output logic                   RVALID,
  output logic                   RLAST,
  output logic [3:0]             RID,
  output logic [`DATA_WIDTH-1:0] RDATA,
  output logic                   err
);

  localparam int ADDR_WIDTH = `ADDR_WIDTH;
  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int IDX_W      = $clog2(MEM_WORDS);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_WAIT  = 2'd1;
  localparam logic [1:0] R_BURST = 2'd2;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [1:0]            r_state;
  logic [3:0]            r_id;
  logic [3:0]            r_len;
  logic [3:0]            r_beat;
  logic [3:0]            r_wait;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;

  logic [1:0]            w_state;
  logic [3:0]            w_id;
  logic [3:0]            w_len;
  logic [4:0]            w_beat;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_hs;
  logic                  w_in_range;
  logic                  err_q;

  assign r_addr_nxt = r_addr + 1'b1;
  assign r_last     = (r_beat == r_len);
  assign w_hs       = (w_state == W_DATA) && WVALID;
  assign w_in_range = (w_beat <= {1'b0, w_len});

  // RDATA is registered when a beat is presented, so a same-cycle write to
  // that word lands after the read (old data) and RDATA stays stable on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_wait  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            r_id   <= ARID;
            r_len  <= ARLEN;
            r_addr <= ARADDR;
            r_beat <= '0;
            if (READ_LATENCY <= 1) begin
              r_state <= R_BURST;
              r_data  <= mem[ARADDR[IDX_W-1:0]];
            end else begin
              r_state <= R_WAIT;
              r_wait  <= 4'(READ_LATENCY - 2);
            end
          end
        end
        R_WAIT: begin
          if (r_wait == '0) begin
            r_state <= R_BURST;
            r_data  <= mem[r_addr[IDX_W-1:0]];
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        R_BURST: begin
          if (RREADY) begin
            if (r_last) begin
              r_state <= R_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
              r_addr <= r_addr_nxt;
              r_data <= mem[r_addr_nxt[IDX_W-1:0]];
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_hs && w_in_range) begin
      mem[w_addr[IDX_W-1:0]] <= WDATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_addr  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID) begin
            w_id    <= AWID;
            w_len   <= AWLEN;
            w_addr  <= AWADDR;
            w_beat  <= '0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            w_addr <= w_addr + 1'b1;
            if (w_beat != '1) begin
              w_beat <= w_beat + 1'b1;
            end
            if ((WID != w_id) || !w_in_range ||
                (WLAST && (w_beat != {1'b0, w_len}))) begin
              err_q <= 1'b1;
            end
            if (WLAST) begin
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign ARREADY = !rst && (r_state == R_IDLE);
  assign RVALID  = !rst && (r_state == R_BURST);
  assign RLAST   = !rst && (r_state == R_BURST) && r_last;
  assign RID     = rst ? '0 : r_id;
  assign RDATA   = rst ? '0 : r_data;

  assign AWREADY = !rst && (w_state == W_IDLE);
  assign WREADY  = !rst && (w_state == W_DATA);
  assign BVALID  = !rst && (w_state == W_RESP);
  assign BID     = rst ? '0 : w_id;
  assign err     = !rst && err_q;

endmodule
